// File: rtl/vga_timing_core.sv
// VGA pixel-timing generator: beam position, sync pulses, active-video flag and
// frame bookkeeping, all registered and mutually aligned.
module vga_timing_core #(
    parameter int unsigned H_DISPLAY   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_DISPLAY   = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter logic        SYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       line_start,
    output logic       frame_start,
    output logic [8:0] frame_no
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_MAX        = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX        = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_DISP       = 10'(H_DISPLAY);
    localparam logic [9:0] V_DISP       = 10'(V_DISPLAY);
    localparam logic [9:0] H_SYNC_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] H_SYNC_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] V_SYNC_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [9:0] hpos_q, hpos_d;
    logic [9:0] vpos_q, vpos_d;
    logic [8:0] frame_no_q, frame_no_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       display_on_q, display_on_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;

    // Next position; flags are derived from the next position so they register with it.
    always_comb begin
        hpos_d        = hpos_q;
        vpos_d        = vpos_q;
        frame_no_d    = frame_no_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        if (en) begin
            if (hpos_q == H_MAX) begin
                hpos_d       = 10'd0;
                line_start_d = 1'b1;
                if (vpos_q == V_MAX) begin
                    vpos_d        = 10'd0;
                    frame_no_d    = frame_no_q + 9'd1;
                    frame_start_d = 1'b1;
                end else begin
                    vpos_d = vpos_q + 10'd1;
                end
            end else begin
                hpos_d = hpos_q + 10'd1;
            end
        end

        hsync_d      = ((hpos_d >= H_SYNC_FIRST) && (hpos_d <= H_SYNC_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d      = ((vpos_d >= V_SYNC_FIRST) && (vpos_d <= V_SYNC_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        display_on_d = (hpos_d < H_DISP) && (vpos_d < V_DISP);
    end

    // Reset presents position (0,0) with no pulses pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos_q        <= 10'd0;
            vpos_q        <= 10'd0;
            frame_no_q    <= 9'd0;
            hsync_q       <= ~SYNC_ACTIVE;
            vsync_q       <= ~SYNC_ACTIVE;
            display_on_q  <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            frame_no_q    <= frame_no_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            display_on_q  <= display_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign frame_no    = frame_no_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign display_on  = display_on_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_core.sv
// Bench for vga_timing_core: default 640x480 instance for line-level behaviour,
// tiny-raster instances (both sync polarities) for frame-level behaviour.
module tb_vga_timing_core;

    typedef struct packed {
        logic [9:0] hpos;
        logic [9:0] vpos;
        logic       hsync;
        logic       vsync;
        logic       display_on;
        logic       line_start;
        logic       frame_start;
        logic [8:0] frame_no;
    } obs_t;

    // Index 0: default raster, index 1: tiny raster (8 x 7)
    localparam int P_HD [2] = '{640, 4};
    localparam int P_HF [2] = '{16, 1};
    localparam int P_HS [2] = '{96, 2};
    localparam int P_HT [2] = '{800, 8};
    localparam int P_VD [2] = '{480, 3};
    localparam int P_VF [2] = '{10, 1};
    localparam int P_VS [2] = '{2, 2};
    localparam int P_VT [2] = '{525, 7};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_b = 1'b1, en_b = 1'b0;
    logic rst_s = 1'b1, en_s = 1'b0;

    logic [9:0] b_hpos, b_vpos, s_hpos, s_vpos, p_hpos, p_vpos;
    logic       b_hs, b_vs, b_don, b_ls, b_fs;
    logic       s_hs, s_vs, s_don, s_ls, s_fs;
    logic       p_hs, p_vs, p_don, p_ls, p_fs;
    logic [8:0] b_fno, s_fno, p_fno;
    obs_t obs_b, obs_s, obs_p;

    assign obs_b = {b_hpos, b_vpos, b_hs, b_vs, b_don, b_ls, b_fs, b_fno};
    assign obs_s = {s_hpos, s_vpos, s_hs, s_vs, s_don, s_ls, s_fs, s_fno};
    assign obs_p = {p_hpos, p_vpos, p_hs, p_vs, p_don, p_ls, p_fs, p_fno};

    vga_timing_core u_big (
        .clk(clk), .rst_n(rst_b), .en(en_b),
        .hpos(b_hpos), .vpos(b_vpos), .hsync(b_hs), .vsync(b_vs),
        .display_on(b_don), .line_start(b_ls), .frame_start(b_fs), .frame_no(b_fno)
    );

    vga_timing_core #(
        .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_ACTIVE(1'b0)
    ) u_small (
        .clk(clk), .rst_n(rst_s), .en(en_s),
        .hpos(s_hpos), .vpos(s_vpos), .hsync(s_hs), .vsync(s_vs),
        .display_on(s_don), .line_start(s_ls), .frame_start(s_fs), .frame_no(s_fno)
    );

    vga_timing_core #(
        .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_ACTIVE(1'b1)
    ) u_pol (
        .clk(clk), .rst_n(rst_s), .en(en_s),
        .hpos(p_hpos), .vpos(p_vpos), .hsync(p_hs), .vsync(p_vs),
        .display_on(p_don), .line_start(p_ls), .frame_start(p_fs), .frame_no(p_fno)
    );

    int vectors = 0;
    int miscompares = 0;
    obs_t sb[$];

    // Model: linear pixel index within the frame, decomposed into (h, v) on demand.
    int mn [2];
    int mf [2];
    bit mls [2];
    bit mfs [2];

    int cnt_hlow, cnt_vlow, cnt_don, cnt_ls, cnt_fs;
    int fs_fno;

    function automatic void model_reset(input int s);
        mn[s] = 0; mf[s] = 0; mls[s] = 1'b0; mfs[s] = 1'b0;
    endfunction

    function automatic void model_step(input int s, input logic e);
        mls[s] = 1'b0;
        mfs[s] = 1'b0;
        if (e) begin
            mn[s] = mn[s] + 1;
            if (mn[s] == P_HT[s] * P_VT[s]) begin
                mn[s]  = 0;
                mf[s]  = (mf[s] + 1) % 512;
                mfs[s] = 1'b1;
            end
            mls[s] = ((mn[s] % P_HT[s]) == 0);
        end
    endfunction

    function automatic obs_t model_obs(input int s, input logic sa);
        obs_t o;
        int h, v;
        h = mn[s] % P_HT[s];
        v = mn[s] / P_HT[s];
        o.hpos        = 10'(h);
        o.vpos        = 10'(v);
        o.hsync       = (h >= P_HD[s] + P_HF[s] && h < P_HD[s] + P_HF[s] + P_HS[s]) ? sa : ~sa;
        o.vsync       = (v >= P_VD[s] + P_VF[s] && v < P_VD[s] + P_VF[s] + P_VS[s]) ? sa : ~sa;
        o.display_on  = (h < P_HD[s]) && (v < P_VD[s]);
        o.line_start  = mls[s];
        o.frame_start = mfs[s];
        o.frame_no    = 9'(mf[s]);
        return o;
    endfunction

    function automatic void clear_counts();
        cnt_hlow = 0; cnt_vlow = 0; cnt_don = 0; cnt_ls = 0; cnt_fs = 0; fs_fno = -1;
    endfunction

    // One pixel-clock cycle on raster s: drive en, push expectation, pop and compare after the edge.
    task automatic step(input int s, input logic e);
        obs_t want;
        obs_t got;
        @(negedge clk);
        en_b = (s == 0) ? e : 1'b0;
        en_s = (s == 1) ? e : 1'b0;
        model_step(s, e);
        sb.push_back(model_obs(s, 1'b0));
        if (s == 1) sb.push_back(model_obs(s, 1'b1));
        @(posedge clk);
        #1;
        got  = (s == 0) ? obs_b : obs_s;
        want = sb.pop_front();
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL sb_raster%0d t=%0t got=%h (h=%0d v=%0d) exp=%h (h=%0d v=%0d)",
                     s, $time, got, got.hpos, got.vpos, want, want.hpos, want.vpos);
        end
        if (s == 1) begin
            want = sb.pop_front();
            vectors++;
            if (obs_p !== want) begin
                miscompares++;
                $display("FAIL sb_polarity t=%0t got=%h exp=%h", $time, obs_p, want);
            end
        end
        if (!got.hsync) cnt_hlow++;
        if (!got.vsync) cnt_vlow++;
        if (got.display_on) cnt_don++;
        if (got.line_start) cnt_ls++;
        if (got.frame_start) begin
            cnt_fs++;
            fs_fno = int'(got.frame_no);
        end
    endtask

    task automatic test_reset();
        obs_t rst_neg, rst_pos;
        rst_neg = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0};
        rst_pos = {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'd0};
        #2;
        rst_b = 1'b0;
        rst_s = 1'b0;
        #1;
        vectors++;
        if (obs_b !== rst_neg) begin
            miscompares++;
            $display("FAIL reset_big got=%h exp=%h", obs_b, rst_neg);
        end
        vectors++;
        if (obs_s !== rst_neg) begin
            miscompares++;
            $display("FAIL reset_small got=%h exp=%h", obs_s, rst_neg);
        end
        vectors++;
        if (obs_p !== rst_pos) begin
            miscompares++;
            $display("FAIL reset_polarity got=%h exp=%h", obs_p, rst_pos);
        end
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        rst_s = 1'b1;
        model_reset(0);
        model_reset(1);
    endtask

    task automatic test_line();
        clear_counts();
        for (int i = 0; i < 800; i++) step(0, 1'b1);
        vectors++;
        if (cnt_hlow != 96) begin
            miscompares++;
            $display("FAIL line_hsync_low got=%0d exp=96", cnt_hlow);
        end
        vectors++;
        if (cnt_don != 640) begin
            miscompares++;
            $display("FAIL line_display_on got=%0d exp=640", cnt_don);
        end
        vectors++;
        if (cnt_ls != 1 || b_ls !== 1'b1) begin
            miscompares++;
            $display("FAIL line_start_pulse got count=%0d last=%b exp count=1 last=1", cnt_ls, b_ls);
        end
        vectors++;
        if (b_hpos !== 10'd0 || b_vpos !== 10'd1) begin
            miscompares++;
            $display("FAIL line_end_pos got=(%0d,%0d) exp=(0,1)", b_hpos, b_vpos);
        end
    endtask

    task automatic test_half_duty();
        clear_counts();
        for (int i = 0; i < 1600; i++) step(0, (i % 2) == 0);
        vectors++;
        if (cnt_ls != 1) begin
            miscompares++;
            $display("FAIL half_duty_line_start got=%0d exp=1", cnt_ls);
        end
        vectors++;
        if (b_hpos !== 10'd0 || b_vpos !== 10'd2) begin
            miscompares++;
            $display("FAIL half_duty_pos got=(%0d,%0d) exp=(0,2)", b_hpos, b_vpos);
        end
    endtask

    task automatic test_async_reset();
        obs_t rst_neg;
        rst_neg = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0};
        for (int i = 0; i < 700; i++) step(0, 1'b1);
        #3;
        rst_b = 1'b0;
        #1;
        vectors++;
        if (obs_b !== rst_neg) begin
            miscompares++;
            $display("FAIL async_reset got=%h exp=%h", obs_b, rst_neg);
        end
        en_b = 1'b0;
        model_reset(0);
        @(negedge clk);
        rst_b = 1'b1;
        step(0, 1'b1);
        vectors++;
        if (b_hpos !== 10'd1 || b_vpos !== 10'd0) begin
            miscompares++;
            $display("FAIL after_reset_pos got=(%0d,%0d) exp=(1,0)", b_hpos, b_vpos);
        end
    endtask

    task automatic test_frame();
        clear_counts();
        for (int i = 0; i < 56; i++) step(1, 1'b1);
        vectors++;
        if (cnt_vlow != 16) begin
            miscompares++;
            $display("FAIL frame_vsync_low got=%0d exp=16", cnt_vlow);
        end
        vectors++;
        if (cnt_don != 12) begin
            miscompares++;
            $display("FAIL frame_display_on got=%0d exp=12", cnt_don);
        end
        vectors++;
        if (cnt_fs != 1 || fs_fno != 1) begin
            miscompares++;
            $display("FAIL frame_start got count=%0d fno=%0d exp count=1 fno=1", cnt_fs, fs_fno);
        end
    endtask

    task automatic test_frame_wrap();
        clear_counts();
        for (int i = 0; i < 511 * 56; i++) step(1, 1'b1);
        vectors++;
        if (cnt_fs != 511) begin
            miscompares++;
            $display("FAIL wrap_frame_count got=%0d exp=511", cnt_fs);
        end
        vectors++;
        if (s_fno !== 9'd0 || s_fs !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_frame_no got fno=%0d fs=%b exp fno=0 fs=1", s_fno, s_fs);
        end
    endtask

    task automatic test_half_duty_frame();
        clear_counts();
        for (int i = 0; i < 112; i++) step(1, (i % 2) == 0);
        vectors++;
        if (cnt_fs != 1 || cnt_ls != 7) begin
            miscompares++;
            $display("FAIL half_duty_frame got fs=%0d ls=%0d exp fs=1 ls=7", cnt_fs, cnt_ls);
        end
        vectors++;
        if (s_fno !== 9'd1 || s_hpos !== 10'd0 || s_vpos !== 10'd0) begin
            miscompares++;
            $display("FAIL half_duty_frame_pos got=(%0d,%0d) fno=%0d exp=(0,0) fno=1",
                     s_hpos, s_vpos, s_fno);
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_half_duty();
        test_async_reset();
        test_frame();
        test_frame_wrap();
        test_half_duty_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_timing_core.md
# vga_timing_core

Pixel-timing generator for the VGA demo tops. Produces the beam position (`hpos`, `vpos`), sync pulses for the Tiny VGA Pmod, the active-video flag and frame bookkeeping (`frame_no`, `frame_start`, `line_start`). It sits directly upstream of the pattern/colour stage, which registers RGB from these outputs. All outputs are registered and mutually aligned, so downstream stages need no edge detectors of their own.

## Interface

**Parameters**
- `H_DISPLAY`, 640: visible pixels per line
- `H_FRONT`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: hsync width, in pixels
- `H_BACK`, 48: horizontal back porch, in pixels
- `V_DISPLAY`, 480: visible lines per frame
- `V_FRONT`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vsync width, in lines
- `V_BACK`, 33: vertical back porch, in lines
- `SYNC_ACTIVE`, 1'b0: level of `hsync`/`vsync` while asserted (0 = negative polarity, as the monitor requires for 640x480)

**Ports**
- `clk` in 1: pixel-domain clock
- `rst_n` in 1: reset, asynchronous, active-low
- `en` in 1: pixel enable; the position advances only on clock edges with `en`=1
- `hpos` out 10: current column, 0..H_TOTAL-1
- `vpos` out 10: current line, 0..V_TOTAL-1
- `hsync` out 1: horizontal sync at `SYNC_ACTIVE` polarity
- `vsync` out 1: vertical sync at `SYNC_ACTIVE` polarity
- `display_on` out 1: high when `hpos`<H_DISPLAY and `vpos`<V_DISPLAY
- `line_start` out 1: one-`clk` pulse on the first cycle a new line's `hpos`=0 is presented
- `frame_start` out 1: one-`clk` pulse on the first cycle `hpos`=0 and `vpos`=0 is presented after a wrap
- `frame_no` out 9: frame counter, wraps 511 -> 0

## Operation

- Derived totals:
  - H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK (800)
  - V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK (525)
- Horizontal counter, on each `clk` edge with `en`=1:
  - `hpos` increments by 1.
  - At H_TOTAL-1 it wraps to 0 and `vpos` advances by 1.
- Vertical counter: `vpos` wraps from V_TOTAL-1 to 0 when `hpos` also wraps.
- Frame counter: `frame_no` increments by 1, modulo 512, on that same (H_TOTAL-1, V_TOTAL-1) -> (0,0) step.
- Sync windows, both bounds inclusive:
  - `hsync` is asserted for `hpos` in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = [656, 751].
  - `vsync` is asserted for `vpos` in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] = [490, 491], for the whole line.
  - Outside these windows each sync sits at `~SYNC_ACTIVE`.
- Alignment: `hsync`, `vsync` and `display_on` are computed from the next position and registered with it. On every cycle they therefore describe the `hpos`/`vpos` presented in that same cycle, with zero skew.
- Pulses:
  - `line_start` is high for exactly one `clk` after `hpos` steps to 0, including at the frame wrap.
  - `frame_start` is high for exactly one `clk` after the frame wrap.
  - Neither pulse re-asserts while `en`=0 holds the position at 0; pulse width is 1 `clk`, not 1 pixel.
- `en`=0: all outputs hold, except that the pulses drop to 0 after their single cycle.
- Width rules: all comparisons are unsigned on 10 bits. Parameters must satisfy H_TOTAL ≤ 1024 and V_TOTAL ≤ 1024; this is not checked in RTL.

## Timing

- Reset values, applied asynchronously on `rst_n`=0:
  - `hpos`=0, `vpos`=0, `frame_no`=0
  - `hsync`=`vsync`=~SYNC_ACTIVE
  - `display_on`=1, since it reflects position (0,0)
  - `line_start`=0, `frame_start`=0
- Reset release: the first enabled edge moves to `hpos`=1. No `frame_start` or `line_start` is produced for the post-reset (0,0).
- Reset mid-frame: all outputs return to their reset values immediately; no partial pulse remains high.
- Latency: 0 cycles between position and flags. The first (0,0) after the wrap is presented one enabled edge after (799,524).
- With `en`=1 permanently:
  - line period = 800 `clk`
  - frame period = 420000 `clk`
  - `frame_start` period = 420000 `clk`

## Test plan

- Reset, then `en`=1 for 800 cycles:
  - `hpos` runs 0..799 and back to 0.
  - `vpos` goes 0 -> 1.
  - `hsync` is low exactly for `hpos` 656..751 (96 cycles).
  - `display_on` is high exactly for `hpos` 0..639.
  - `line_start` pulses once, on the cycle `hpos` returns to 0.
- Run one full frame (420000 cycles):
  - `vsync` is low for exactly 1600 cycles, covering `vpos` 490..491.
  - `display_on` is high for 307200 cycles in total.
  - `frame_start` pulses once, and on that cycle `frame_no` steps 0 -> 1.
- Toggle `en` at 1/2 duty (1010...) for 1600 cycles:
  - Position advances 800 steps, to (0,1).
  - `line_start` is 1 clock wide even though the position holds for 2 clocks.
- Force `frame_no` to 511 by running 511 frames, or via a fast-forward bench hook:
  - The next wrap gives `frame_no`=0 with `frame_start`=1.
- Assert `rst_n`=0 asynchronously at (700,300), between clock edges:
  - Outputs go to reset values before the next edge.
  - After release, the next edge gives `hpos`=1, `vpos`=0.
- Set parameter `SYNC_ACTIVE`=1:
  - The sync windows are unchanged and their polarity is inverted.
  - Idle sync level is 0.
